exc_ctrl: RTL and testbench



---
 rtl/exc_ctrl_pkg.sv | 40 ++++
 rtl/exc_prio_enc.sv | 28 ++
 rtl/exc_ctrl.sv | 154 +++++++++++++++
 tb/tb_exc_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception controller: exception codes, flag bit
// indices, CP0 register addresses and status bit positions.
package exc_ctrl_pkg;

    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_RI   = 32'h0000_000a;
    localparam logic [31:0] EXC_TRAP = 32'h0000_000d;
    localparam logic [31:0] EXC_OV   = 32'h0000_000c;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    // Bit positions inside mem_exc_i = {eret, ovf, trap, syscall, ri}
    localparam int EXC_BIT_RI      = 0;
    localparam int EXC_BIT_SYSCALL = 1;
    localparam int EXC_BIT_TRAP    = 2;
    localparam int EXC_BIT_OVF     = 3;
    localparam int EXC_BIT_ERET    = 4;

    localparam logic [4:0] CP0_ADDR_STATUS = 5'd12;
    localparam logic [4:0] CP0_ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_ADDR_EPC    = 5'd14;

    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } exc_state_e;

    // An interrupt is pending when an unmasked line is raised, interrupts are
    // globally enabled and we are not already inside an exception handler.
    function automatic logic int_pending_f(input logic [7:0] ip,
                                           input logic [7:0] im,
                                           input logic       ie,
                                           input logic       exl);
        return (|(ip & im)) && ie && !exl;
    endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder turning the pending interrupt and the MEM
// exception flags into the single exception code reported to CP0.
module exc_prio_enc
    import exc_ctrl_pkg::*;
(
    input  logic        int_pending,
    input  logic [4:0]  mem_exc,
    output logic [31:0] code
);

    always_comb begin
        code = '0;
        if (int_pending) begin
            code = EXC_INT;
        end else if (mem_exc[EXC_BIT_RI]) begin
            code = EXC_RI;
        end else if (mem_exc[EXC_BIT_SYSCALL]) begin
            code = EXC_SYS;
        end else if (mem_exc[EXC_BIT_TRAP]) begin
            code = EXC_TRAP;
        end else if (mem_exc[EXC_BIT_OVF]) begin
            code = EXC_OV;
        end else if (mem_exc[EXC_BIT_ERET]) begin
            code = EXC_ERET;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception controller between MEM and CP0: selects one exception, reports it,
// then flushes the pipeline and redirects the PC. Reset rst is async active-low.
// Define EXC_INT_SYNC_EN to pass int_i through a two-flop synchronizer.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    input  logic [4:0]  mem_exc_i,
    input  logic        stall_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_data_i,
    input  logic [5:0]  int_i,
    input  logic        timer_int_i,
    output logic [5:0]  int_o,
    output logic [31:0] excepttype_o,
    output logic [31:0] cur_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);

    localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

    exc_state_e  state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic [31:0] exc_d, addr_d, new_pc_d;
    logic        ds_d, flush_d;

    logic [31:0] eff_status, eff_cause, eff_epc;
    logic        int_pending;
    logic [31:0] sel_code;
    logic        accept;
    logic [31:0] target;
    logic [5:0]  int_s;
    logic        unused_bits;

    // A CP0 write still in WB is newer than the register file contents.
    always_comb begin
        eff_status = cp0_status_i;
        eff_cause  = cp0_cause_i;
        eff_epc    = cp0_epc_i;
        if (wb_cp0_we_i) begin
            if (wb_cp0_waddr_i == CP0_ADDR_STATUS) eff_status = wb_cp0_data_i;
            if (wb_cp0_waddr_i == CP0_ADDR_CAUSE)  eff_cause[9:8] = wb_cp0_data_i[9:8];
            if (wb_cp0_waddr_i == CP0_ADDR_EPC)    eff_epc = wb_cp0_data_i;
        end
    end

    assign unused_bits = ^{eff_status[31:16], eff_status[7:2],
                           eff_cause[31:16], eff_cause[7:0]};

    assign int_pending = int_pending_f(eff_cause[15:8], eff_status[15:8],
                                       eff_status[STATUS_IE], eff_status[STATUS_EXL]);

    exc_prio_enc u_prio (
        .int_pending (int_pending),
        .mem_exc     (mem_exc_i),
        .code        (sel_code)
    );

    assign accept = (state == ST_IDLE) && mem_valid_i && !stall_i && (sel_code != '0);
    assign target = (sel_code == EXC_ERET) ? eff_epc : EXC_VECTOR;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= ST_IDLE;
            cnt               <= '0;
            excepttype_o      <= '0;
            cur_inst_addr_o   <= '0;
            is_in_delayslot_o <= 1'b0;
            flush_o           <= 1'b0;
            new_pc_o          <= '0;
        end else begin
            state             <= state_d;
            cnt               <= cnt_d;
            excepttype_o      <= exc_d;
            cur_inst_addr_o   <= addr_d;
            is_in_delayslot_o <= ds_d;
            flush_o           <= flush_d;
            new_pc_o          <= new_pc_d;
        end
    end

    // The report fields pulse for one cycle; flush and redirect hold until the
    // counter runs out.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        exc_d    = '0;
        addr_d   = '0;
        ds_d     = 1'b0;
        flush_d  = flush_o;
        new_pc_d = new_pc_o;
        case (state)
            ST_IDLE: begin
                flush_d  = 1'b0;
                new_pc_d = '0;
                if (accept) begin
                    exc_d    = sel_code;
                    addr_d   = mem_pc_i;
                    ds_d     = mem_in_delayslot_i;
                    flush_d  = 1'b1;
                    new_pc_d = target;
                    cnt_d    = CNT_LOAD;
                    state_d  = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (cnt == 4'd0) begin
                    flush_d  = 1'b0;
                    new_pc_d = '0;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef EXC_INT_SYNC_EN
    logic [5:0] int_meta, int_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int_meta <= '0;
            int_sync <= '0;
        end else begin
            int_meta <= int_i;
            int_sync <= int_meta;
        end
    end

    assign int_s = int_sync;
`else
    assign int_s = int_i;
`endif

    assign int_o = {int_s[5] | timer_int_i, int_s[4:0]};

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: two instances (2 and 4 flush cycles)
// driven by directed and random stimulus against a behavioural model.
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        mem_ds;
    logic [4:0]  mem_exc;
    logic        stall;
    logic [31:0] cp0_status, cp0_cause, cp0_epc;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_data;
    logic [5:0]  int_in;
    logic        timer;

    logic [5:0]  int_a, int_b;
    logic [31:0] exc_a, exc_b, addr_a, addr_b, npc_a, npc_b;
    logic        ds_a, ds_b, flush_a, flush_b;

    int checks_total  = 0;
    int checks_passed = 0;

    // Model state per instance: cycles of flush left, the one-cycle report,
    // and the redirect target held during the flush.
    int          flush_len[2] = '{2, 4};
    int          m_left[2];
    logic [31:0] m_code[2];
    logic [31:0] m_addr[2];
    logic        m_ds[2];
    logic [31:0] m_redirect[2];
    logic [5:0]  int_d1, int_d2;
    logic [5:0]  exp_int;

    logic [31:0] prio_code[5] = '{32'ha, 32'h8, 32'hd, 32'hc, 32'he};

    always #5 clk = ~clk;

    exc_ctrl #(.EXC_VECTOR(32'h20), .FLUSH_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .mem_valid_i(mem_valid), .mem_pc_i(mem_pc),
        .mem_in_delayslot_i(mem_ds), .mem_exc_i(mem_exc), .stall_i(stall),
        .cp0_status_i(cp0_status), .cp0_cause_i(cp0_cause), .cp0_epc_i(cp0_epc),
        .wb_cp0_we_i(wb_we), .wb_cp0_waddr_i(wb_waddr), .wb_cp0_data_i(wb_data),
        .int_i(int_in), .timer_int_i(timer), .int_o(int_a),
        .excepttype_o(exc_a), .cur_inst_addr_o(addr_a), .is_in_delayslot_o(ds_a),
        .flush_o(flush_a), .new_pc_o(npc_a)
    );

    exc_ctrl #(.EXC_VECTOR(32'h20), .FLUSH_CYCLES(4)) dut_b (
        .clk(clk), .rst(rst), .mem_valid_i(mem_valid), .mem_pc_i(mem_pc),
        .mem_in_delayslot_i(mem_ds), .mem_exc_i(mem_exc), .stall_i(stall),
        .cp0_status_i(cp0_status), .cp0_cause_i(cp0_cause), .cp0_epc_i(cp0_epc),
        .wb_cp0_we_i(wb_we), .wb_cp0_waddr_i(wb_waddr), .wb_cp0_data_i(wb_data),
        .int_i(int_in), .timer_int_i(timer), .int_o(int_b),
        .excepttype_o(exc_b), .cur_inst_addr_o(addr_b), .is_in_delayslot_o(ds_b),
        .flush_o(flush_b), .new_pc_o(npc_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Reference: the exception the controller should pick from the current inputs.
    function automatic logic [31:0] ref_code();
        logic [31:0] st, ca;
        st = cp0_status;
        ca = cp0_cause;
        if (wb_we && wb_waddr == 5'd12) st = wb_data;
        if (wb_we && wb_waddr == 5'd13) ca[9:8] = wb_data[9:8];
        if (((ca[15:8] & st[15:8]) != 8'h0) && st[0] && !st[1]) return 32'h1;
        for (int k = 0; k < 5; k++) begin
            if (mem_exc[k]) return prio_code[k];
        end
        return 32'h0;
    endfunction

    function automatic logic [31:0] ref_target(input logic [31:0] code);
        if (code != 32'he) return 32'h20;
        if (wb_we && wb_waddr == 5'd14) return wb_data;
        return cp0_epc;
    endfunction

    task automatic driveInputs(input logic v, input logic [31:0] pc, input logic ds,
                               input logic [4:0] exc, input logic stl,
                               input logic [31:0] st, input logic [31:0] ca,
                               input logic [31:0] epc, input logic we,
                               input logic [4:0] wa, input logic [31:0] wd,
                               input logic [5:0] iv, input logic tm);
        mem_valid = v;   mem_pc = pc;     mem_ds = ds;    mem_exc = exc;
        stall = stl;     cp0_status = st; cp0_cause = ca; cp0_epc = epc;
        wb_we = we;      wb_waddr = wa;   wb_data = wd;   int_in = iv;
        timer = tm;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic ds,
                                 input logic [4:0] exc, input logic stl,
                                 input logic [31:0] st, input logic [31:0] ca,
                                 input logic [31:0] epc, input logic we,
                                 input logic [4:0] wa, input logic [31:0] wd,
                                 input logic [5:0] iv, input logic tm);
        @(negedge clk);
        driveInputs(v, pc, ds, exc, stl, st, ca, epc, we, wa, wd, iv, tm);
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 32'h0, 1'b0, 5'h0, 1'b0, 32'h0, 32'h0, 32'h0,
                      1'b0, 5'h0, 32'h0, 6'h0, 1'b0);
    endtask

    task automatic resetModel();
        for (int i = 0; i < 2; i++) begin
            m_left[i] = 0; m_code[i] = '0; m_addr[i] = '0;
            m_ds[i] = 1'b0; m_redirect[i] = '0;
        end
        int_d1 = '0;
        int_d2 = '0;
    endtask

    task automatic checkInstance(input int i, input string pfx,
                                 input logic [31:0] exc, input logic [31:0] addr,
                                 input logic ds, input logic flush,
                                 input logic [31:0] npc);
        checkOutput({pfx, "excepttype"}, exc, m_code[i]);
        checkOutput({pfx, "inst_addr"}, addr, m_addr[i]);
        checkOutput({pfx, "delayslot"}, 32'(ds), 32'(m_ds[i]));
        checkOutput({pfx, "flush"}, 32'(flush), 32'(m_left[i] > 0));
        checkOutput({pfx, "new_pc"}, npc, (m_left[i] > 0) ? m_redirect[i] : 32'h0);
    endtask

    // Advance the model across the next rising edge, then compare both DUTs.
    task automatic advanceClock();
        logic [31:0] code, tgt;
        code = ref_code();
        tgt  = ref_target(code);
        for (int i = 0; i < 2; i++) begin
            m_code[i] = '0; m_addr[i] = '0; m_ds[i] = 1'b0;
            if (m_left[i] > 0) begin
                m_left[i]--;
            end else if (mem_valid && !stall && code != 32'h0) begin
                m_left[i]     = flush_len[i];
                m_code[i]     = code;
                m_addr[i]     = mem_pc;
                m_ds[i]       = mem_ds;
                m_redirect[i] = tgt;
            end
        end
`ifdef EXC_INT_SYNC_EN
        int_d2  = int_d1;
        int_d1  = int_in;
        exp_int = {int_d2[5] | timer, int_d2[4:0]};
`else
        exp_int = {int_in[5] | timer, int_in[4:0]};
`endif
        @(posedge clk);
        #1;
        checkInstance(0, "A_", exc_a, addr_a, ds_a, flush_a, npc_a);
        checkInstance(1, "B_", exc_b, addr_b, ds_b, flush_b, npc_b);
        checkOutput("int_o", 32'(int_a), 32'(exp_int));
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) begin
            applyIdle();
            advanceClock();
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cnt_a, cnt_b;
        rst = 1'b0;
        driveInputs(1'b0, 32'h0, 1'b0, 5'h0, 1'b0, 32'h0, 32'h0, 32'h0,
                    1'b0, 5'h0, 32'h0, 6'h0, 1'b0);
        resetModel();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_exc", exc_a, 32'h0);
        checkOutput("rst_addr", addr_a, 32'h0);
        checkOutput("rst_flush", 32'(flush_a), 32'h0);
        checkOutput("rst_new_pc", npc_b, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        idleCycles(2);

        $display("[TB] syscall");
        applyStimulus(1'b1, 32'h100, 1'b0, 5'b00010, 1'b0, 32'h0, 32'h0, 32'h0,
                      1'b0, 5'h0, 32'h0, 6'h0, 1'b0);
        advanceClock();
        checkOutput("sys_code", exc_a, 32'h8);
        checkOutput("sys_addr", addr_a, 32'h100);
        checkOutput("sys_new_pc", npc_a, 32'h20);
        idleCycles(1);
        checkOutput("sys_pulse_end", exc_a, 32'h0);
        checkOutput("sys_flush_2nd", 32'(flush_a), 32'h1);
        idleCycles(1);
        checkOutput("sys_flush_end", 32'(flush_a), 32'h0);
        idleCycles(3);

        $display("[TB] eret with forwarded epc");
        applyStimulus(1'b1, 32'h180, 1'b0, 5'b10000, 1'b0, 32'h0, 32'h0, 32'h300,
                      1'b1, 5'd14, 32'h400, 6'h0, 1'b0);
        advanceClock();
        checkOutput("eret_code", exc_a, 32'he);
        checkOutput("eret_new_pc", npc_a, 32'h400);
        idleCycles(5);

        $display("[TB] interrupt masking");
        applyStimulus(1'b1, 32'h1c0, 1'b0, 5'b10000, 1'b0, 32'h0000_0401, 32'h0000_0400,
                      32'h0, 1'b0, 5'h0, 32'h0, 6'h0, 1'b0);
        advanceClock();
        checkOutput("int_code", exc_a, 32'h1);
        idleCycles(5);
        applyStimulus(1'b1, 32'h1c4, 1'b0, 5'b00000, 1'b0, 32'h0000_0403, 32'h0000_0400,
                      32'h0, 1'b0, 5'h0, 32'h0, 6'h0, 1'b0);
        advanceClock();
        checkOutput("int_exl_masked", 32'(flush_a), 32'h0);
        idleCycles(1);

        $display("[TB] simultaneous flags in delay slot");
        applyStimulus(1'b1, 32'h204, 1'b1, 5'b01101, 1'b0, 32'h0, 32'h0, 32'h0,
                      1'b0, 5'h0, 32'h0, 6'h0, 1'b0);
        advanceClock();
        checkOutput("multi_code", exc_a, 32'ha);
        checkOutput("multi_ds", 32'(ds_a), 32'h1);
        applyStimulus(1'b1, 32'h208, 1'b0, 5'b00010, 1'b0, 32'h0, 32'h0, 32'h0,
                      1'b0, 5'h0, 32'h0, 6'h0, 1'b0);
        advanceClock();
        checkOutput("flush_ignores", exc_a, 32'h0);
        idleCycles(5);

        $display("[TB] stall then reset during flush");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 32'h300, 1'b0, 5'b01000, 1'b1, 32'h0, 32'h0, 32'h0,
                          1'b0, 5'h0, 32'h0, 6'h0, 1'b0);
            advanceClock();
            checkOutput("stall_hold", 32'(flush_a), 32'h0);
        end
        applyStimulus(1'b1, 32'h300, 1'b0, 5'b01000, 1'b0, 32'h0, 32'h0, 32'h0,
                      1'b0, 5'h0, 32'h0, 6'h0, 1'b0);
        advanceClock();
        checkOutput("stall_release", exc_a, 32'hc);
        #2;
        rst = 1'b0;
        driveInputs(1'b0, 32'h0, 1'b0, 5'h0, 1'b0, 32'h0, 32'h0, 32'h0,
                    1'b0, 5'h0, 32'h0, 6'h0, 1'b0);
        #1;
        checkOutput("arst_exc_a", exc_a, 32'h0);
        checkOutput("arst_flush_a", 32'(flush_a), 32'h0);
        checkOutput("arst_new_pc_a", npc_a, 32'h0);
        checkOutput("arst_addr_a", addr_a, 32'h0);
        checkOutput("arst_flush_b", 32'(flush_b), 32'h0);
        checkOutput("arst_exc_b", exc_b, 32'h0);
        resetModel();
        @(negedge clk);
        rst = 1'b1;
        idleCycles(2);

        $display("[TB] timer interrupt and flush length");
        applyStimulus(1'b1, 32'h500, 1'b0, 5'b00010, 1'b0, 32'h0, 32'h0, 32'h0,
                      1'b0, 5'h0, 32'h0, 6'h01, 1'b1);
        advanceClock();
        checkOutput("timer_int", 32'(int_a[5]), 32'h1);
        cnt_a = int'(flush_a);
        cnt_b = int'(flush_b);
        for (int k = 0; k < 6; k++) begin
            applyIdle();
            advanceClock();
            cnt_a += int'(flush_a);
            cnt_b += int'(flush_b);
        end
        checkOutput("flush_len_2", 32'(cnt_a), 32'd2);
        checkOutput("flush_len_4", 32'(cnt_b), 32'd4);

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            logic [4:0] exc_r;
            for (int b = 0; b < 5; b++) exc_r[b] = ($urandom_range(0, 4) == 0);
            applyStimulus($urandom_range(0, 3) != 0, $urandom & 32'hffff_fffc,
                          1'($urandom_range(0, 1)), exc_r, $urandom_range(0, 3) == 0,
                          {16'h0, 8'($urandom), 6'($urandom), 2'($urandom)},
                          {16'h0, 8'($urandom), 8'($urandom)}, $urandom,
                          1'($urandom_range(0, 1)), 5'($urandom_range(11, 15)), $urandom,
                          6'($urandom), 1'($urandom_range(0, 1)));
            advanceClock();
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
